// File: rtl/nn_pkg.sv
// Shared types and constants for the NN output-stage blocks.
//   fp32_t          : raw IEEE-754 single-precision word
//   FP32_EXP_NAN    : all-ones exponent (inf/NaN encodings)
//   NUM_CLASSES_DEF : default classifier width
//   argmax_state_e  : argmax controller states
//   fp32_is_nan()   : true for exp=FF with a non-zero mantissa
package nn_pkg;

  typedef logic [31:0] fp32_t;

  localparam logic [7:0] FP32_EXP_NAN    = 8'hFF;
  localparam int         NUM_CLASSES_DEF = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } argmax_state_e;

  function automatic logic fp32_is_nan(input fp32_t v);
    return (v[30:23] == FP32_EXP_NAN) && (v[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/fp32_gt.sv
// Combinational strict greater-than on fp32 words (a > b).
//   a, b : fp32 operands
//   gt   : 1 when a ranks strictly above b
// Ordering: NaN ranks below -inf (a NaN never wins, any number beats a NaN),
// +0 and -0 compare equal, everything else follows IEEE numeric order.
module fp32_gt
  import nn_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  output logic  gt
);

  logic a_nan;
  logic b_nan;
  logic both_zero;

  assign a_nan     = fp32_is_nan(a);
  assign b_nan     = fp32_is_nan(b);
  assign both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);

  always_comb begin
    gt = 1'b0;
    if (a_nan) begin
      gt = 1'b0;
    end else if (b_nan) begin
      gt = 1'b1;
    end else if (a[31] != b[31]) begin
      // Positive beats negative unless the pair is just +0/-0.
      gt = !a[31] && !both_zero;
    end else if (!a[31]) begin
      gt = a[30:0] > b[30:0];
    end else begin
      // Both negative: the smaller magnitude is the larger value.
      gt = a[30:0] < b[30:0];
    end
  end

endmodule

// File: rtl/argmax_stream_ctrl.sv
// Streaming argmax over one frame of NUM_CLASSES fp32 scores.
//   Clk, Reset_n          : clock, asynchronous active-low reset
//   clear                 : synchronous abort back to IDLE (highest priority)
//   in_valid/in_ready     : score stream handshake
//   in_score, in_last     : score word and producer end-of-frame marker
//   res_valid/res_ready   : result handshake
//   res_class             : index of the maximum score (earliest on ties)
//   res_err               : frame length did not match NUM_CLASSES
//   res_score             : winning score, only when ARGMAX_SCORE_OUT_EN is defined
module argmax_stream_ctrl
  import nn_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int IDX_W       = 5
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_score,
  input  logic             in_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [IDX_W-1:0] res_class,
`ifdef ARGMAX_SCORE_OUT_EN
  output logic             res_err,
  output logic [31:0]      res_score
`else
  output logic             res_err
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  argmax_state_e    state_q, state_d;
  logic [IDX_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] best_q, best_d;
  fp32_t            max_q, max_d;
  logic             in_ready_q, in_ready_d;
  logic             res_valid_q, res_valid_d;
  logic [IDX_W-1:0] res_class_q, res_class_d;
  logic             res_err_q, res_err_d;

  logic accept;
  logic score_gt;
  logic at_end;

  fp32_t score_w;
  assign score_w = in_score;

  fp32_gt u_gt (
    .a  (score_w),
    .b  (max_q),
    .gt (score_gt)
  );

  assign accept = in_valid && in_ready_q;
  assign at_end = (count_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    best_d      = best_q;
    max_d       = max_q;
    res_valid_d = res_valid_q;
    res_class_d = res_class_q;
    res_err_d   = res_err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          max_d   = score_w;
          best_d  = '0;
          count_d = IDX_W'(1);
          if (in_last) begin
            // A one-beat frame is always short.
            state_d     = DONE;
            res_valid_d = 1'b1;
            res_class_d = '0;
            res_err_d   = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          if (score_gt) begin
            max_d  = score_w;
            best_d = count_q;
          end
          if (at_end || in_last) begin
            // Result must already include the closing beat.
            state_d     = DONE;
            res_valid_d = 1'b1;
            res_class_d = score_gt ? count_q : best_q;
            res_err_d   = (in_last != at_end);
          end else begin
            count_d = count_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        if (res_valid_q && res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d != DONE);

    if (clear) begin
      state_d     = IDLE;
      count_d     = '0;
      best_d      = '0;
      max_d       = '0;
      in_ready_d  = 1'b0;
      res_valid_d = 1'b0;
      res_class_d = '0;
      res_err_d   = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      best_q      <= '0;
      max_q       <= '0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_class_q <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      best_q      <= best_d;
      max_q       <= max_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      res_class_q <= res_class_d;
      res_err_q   <= res_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res_class = res_class_q;
  assign res_err   = res_err_q;

`ifdef ARGMAX_SCORE_OUT_EN
  // max_q is frozen in DONE, so it doubles as the result score register.
  assign res_score = max_q;
`endif

endmodule

// File: tb/tb_argmax_stream_ctrl.sv
module tb_argmax_stream_ctrl;

  localparam int IDX_W = 5;

  logic             Clk = 1'b0;
  logic             Reset_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_score = 32'd0;
  logic             in_last = 1'b0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [IDX_W-1:0] res_class;
  logic             res_err;
`ifdef ARGMAX_SCORE_OUT_EN
  logic [31:0]      res_score;
`endif

  argmax_stream_ctrl #(.NUM_CLASSES(10), .IDX_W(IDX_W)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_score  (in_score),
    .in_last   (in_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_class (res_class),
`ifdef ARGMAX_SCORE_OUT_EN
    .res_err   (res_err),
    .res_score (res_score)
`else
    .res_err   (res_err)
`endif
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       nm;
    logic [31:0] sc [10];
    int          last_at;   // beat carrying in_last, -1 for none
    int          exp_class;
    logic        exp_err;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic meta(input int i, input string nm, input int last_at,
                      input int cls, input logic err);
    vecs[i].nm = nm;
    vecs[i].last_at = last_at;
    vecs[i].exp_class = cls;
    vecs[i].exp_err = err;
  endtask

  task automatic send(input logic [31:0] s, input logic l);
    int g = 0;
    in_valid = 1'b1;
    in_score = s;
    in_last  = l;
    @(negedge Clk);
    while (!in_ready && g < 50) begin
      g++;
      @(negedge Clk);
    end
    if (g >= 50) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_frame(input int vi, input int hold, input logic do_hs);
    int   n;
    int   t0 = 0;
    logic early = 1'b0;
    logic unstable = 1'b0;
    n = (vecs[vi].last_at >= 0) ? vecs[vi].last_at + 1 : 10;
    for (int b = 0; b < n; b++) begin
      send(vecs[vi].sc[b], b == vecs[vi].last_at);
      if (b == 0) t0 = cyc;
      if (b < n - 1 && res_valid) early = 1'b1;
    end
    chk({vecs[vi].nm, "_early_valid"}, {31'd0, early}, 32'd0);
    chk({vecs[vi].nm, "_valid"}, {31'd0, res_valid}, 32'd1);
    chk({vecs[vi].nm, "_latency"}, cyc - t0, n - 1);
    chk({vecs[vi].nm, "_class"}, {27'd0, res_class}, vecs[vi].exp_class);
    chk({vecs[vi].nm, "_err"}, {31'd0, res_err}, {31'd0, vecs[vi].exp_err});
    $display("frame %s: class=%0d err=%0d", vecs[vi].nm, res_class, res_err);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge Clk);
        #1;
        if (!res_valid || in_ready || res_class !== IDX_W'(vecs[vi].exp_class))
          unstable = 1'b1;
      end
      chk({vecs[vi].nm, "_hold_stable"}, {31'd0, unstable}, 32'd0);
    end
    if (do_hs) begin
      res_ready = 1'b1;
      @(posedge Clk);
      #1;
      res_ready = 1'b0;
      chk({vecs[vi].nm, "_hs_valid_drop"}, {31'd0, res_valid}, 32'd0);
      chk({vecs[vi].nm, "_hs_ready_back"}, {31'd0, in_ready}, 32'd1);
    end
  endtask

  localparam logic [31:0] NAN_Q = 32'h7FC00000;

  initial begin
    vecs[0].sc = '{32'h3DCCCCCD, 32'h3F000000, 32'h3E4CCCCD, 32'h40000000, 32'h3E99999A,
                   32'h3E800000, 32'h3F800000, 32'h3FC00000, 32'h3F400000, 32'h3DCCCCCD};
    meta(0, "ramp", 9, 3, 1'b0);
    vecs[1].sc = '{32'hC0A00000, 32'hC0800000, 32'hC0400000, 32'hC0000000, 32'hBF800000,
                   32'hC0A00000, 32'hC0800000, 32'hBF000000, 32'hC0400000, 32'hC0000000};
    meta(1, "neg", 9, 7, 1'b0);
    vecs[2].sc = '{32'h3F000000, 32'h3F000000, 32'h3F800000, 32'h3F000000, 32'h3E800000,
                   32'h3F000000, 32'h3F800000, 32'h3F400000, 32'h3F000000, 32'h3F000000};
    meta(2, "tie", 9, 2, 1'b0);
    vecs[3].sc = '{32'h7F800001, NAN_Q, NAN_Q, NAN_Q, 32'hFF800000,
                   NAN_Q, NAN_Q, NAN_Q, NAN_Q, NAN_Q};
    meta(3, "nan", 9, 4, 1'b0);
    vecs[4].sc = '{32'h00000000, 32'h80000000, NAN_Q, NAN_Q, NAN_Q,
                   NAN_Q, NAN_Q, NAN_Q, NAN_Q, NAN_Q};
    meta(4, "pzero", 9, 0, 1'b0);
    vecs[5].sc = '{32'h80000000, 32'h00000000, NAN_Q, NAN_Q, NAN_Q,
                   NAN_Q, NAN_Q, NAN_Q, NAN_Q, NAN_Q};
    meta(5, "nzero", 9, 0, 1'b0);
    vecs[6].sc = '{32'h3DCCCCCD, 32'h3F000000, 32'h40000000, 32'h3E99999A, 32'h3F800000,
                   32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    meta(6, "short", 4, 2, 1'b1);
    vecs[7].sc = '{32'h3DCCCCCD, 32'h3E4CCCCD, 32'h3E99999A, 32'h3F000000, 32'h3F800000,
                   32'h40000000, 32'h3FC00000, 32'h3E800000, 32'h3F400000, 32'h3DCCCCCD};
    meta(7, "nolast", -1, 5, 1'b1);
    vecs[8].sc = '{32'hBF800000, 32'h3F000000, 32'hC0000000, 32'h3E800000, 32'h3F800000,
                   32'h3F400000, 32'h3FC00000, 32'h3E99999A, 32'h3E4CCCCD, 32'h40000000};
    meta(8, "max9", 9, 9, 1'b0);
    vecs[9].sc = '{32'h3F800000, 32'h0, 32'h0, 32'h0, 32'h0,
                   32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    meta(9, "single", 0, 0, 1'b1);
    vecs[10].sc = '{32'hC0000000, 32'hBF800000, 32'h80000000, 32'h3E800000, 32'hBF000000,
                    32'h3E4CCCCD, 32'h3E800000, 32'h00000000, 32'hC0A00000, 32'hFF800000};
    meta(10, "mixsign", 9, 3, 1'b0);

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_class", {27'd0, res_class}, 32'd0);
    chk("rst_res_err", {31'd0, res_err}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // Table-driven frames; the first one also holds its result for 20 cycles.
    for (int i = 0; i < NV; i++) run_frame(i, (i == 0) ? 20 : 0, 1'b1);

    // Clear on beat 4 (with a valid beat on the wire), then a fresh frame.
    for (int b = 0; b < 4; b++) send(vecs[7].sc[b], 1'b0);
    in_valid = 1'b1;
    in_score = 32'h7F000000;
    clear    = 1'b1;
    @(posedge Clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clear_in_ready", {31'd0, in_ready}, 32'd0);
    chk("clear_res_valid", {31'd0, res_valid}, 32'd0);
    run_frame(8, 0, 1'b1);

    // Clear together with res_ready in DONE discards the result.
    run_frame(6, 0, 1'b0);
    clear     = 1'b1;
    res_ready = 1'b1;
    @(posedge Clk);
    #1;
    clear     = 1'b0;
    res_ready = 1'b0;
    chk("clr_done_valid", {31'd0, res_valid}, 32'd0);
    chk("clr_done_class", {27'd0, res_class}, 32'd0);
    chk("clr_done_err", {31'd0, res_err}, 32'd0);
    run_frame(0, 0, 1'b1);

    // Asynchronous reset mid-frame.
    for (int b = 0; b < 3; b++) send(vecs[0].sc[b], 1'b0);
    #3;
    Reset_n = 1'b0;
    #1;
    chk("arst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_mid_res_valid", {31'd0, res_valid}, 32'd0);
    repeat (2) @(posedge Clk);
    #2;
    Reset_n = 1'b1;

    // Asynchronous reset while a result is pending.
    run_frame(6, 0, 1'b0);
    #3;
    Reset_n = 1'b0;
    #1;
    chk("arst_done_res_valid", {31'd0, res_valid}, 32'd0);
    chk("arst_done_res_class", {27'd0, res_class}, 32'd0);
    chk("arst_done_res_err", {31'd0, res_err}, 32'd0);
    chk("arst_done_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge Clk);
    #2;
    Reset_n = 1'b1;
    run_frame(1, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/argmax_stream_ctrl.md
Name: argmax_stream_ctrl

Overview:
Sequential argmax controller at the output of the NN classifier layer. It accepts one fp32 class score per cycle over a valid/ready stream and keeps a running maximum with a single shared comparator. After NUM_CLASSES scores it presents the winning class index through a valid/ready result port. It replaces the fully parallel compare tree when scores arrive serially from the layer accumulator.

Parameters:
NUM_CLASSES, 10, scores per frame (2..31)
IDX_W, 5, width of class index and element counter

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
clear  in  1  synchronous abort; drops current frame and returns to IDLE
in_valid  in  1  score valid
in_ready  out  1  controller can accept a score
in_score  in  32  IEEE-754 single score
in_last  in  1  producer marks final score of frame
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
res_class  out  IDX_W  index of maximum score
res_err  out  1  frame length mismatch flag for this result

Behaviour:
- Reset (async, Reset_n=0): state=IDLE, in_ready=0, res_valid=0, res_class=0, res_err=0, count=0, running max=0, best index=0.
- States: IDLE, ACCUM, DONE. in_ready=1 in IDLE and ACCUM; 0 in DONE.
- IDLE: on accept (in_valid&in_ready), load max=in_score, best=0, count=1, go to ACCUM. If in_last is also set on this beat, go to DONE with err=1.
- ACCUM: on accept, if gt(in_score,max) then max<=in_score, best<=count; count<=count+1. A frame closes when count==NUM_CLASSES-1 or in_last=1 on the accepted beat. Go to DONE. err=1 if in_last does not coincide with count==NUM_CLASSES-1.
- Latency: res_valid rises the cycle after the closing beat is accepted. A full frame takes NUM_CLASSES+1 cycles at full rate.
- DONE: hold res_valid, res_class and res_err stable until res_valid&res_ready, then go to IDLE. In that same cycle res_valid drops; a new frame can start the next cycle.
- Comparator gt(a,b), strict greater-than:
  - Both non-NaN, signs differ: positive wins, except that +0 and -0 are equal (not greater).
  - Both positive: unsigned compare of a[30:0] vs b[30:0].
  - Both negative: a>b iff a[30:0] < b[30:0].
  - NaN (exp=8'hFF, mant!=0) ranks below -inf. A NaN never replaces; any non-NaN replaces a NaN max.
- Ties keep the earlier (lower) index.
- clear has priority over all transitions. Registers return to reset values (except that Reset_n is async) in the next cycle, including mid-ACCUM and in DONE with an unaccepted result.
- Simultaneous clear and res_ready in DONE: the result is discarded and the handshake is not counted.
- count never wraps: the frame closes at NUM_CLASSES-1.

Optional Feature:
ARGMAX_SCORE_OUT_EN
- Defined: adds output port res_score[31:0] carrying the winning fp32 score. It is valid with res_valid, held stable in DONE, and reset to 0.
- Undefined: the port is absent, and the max register stays internal only.

Decomposition:
- nn_pkg: typedef fp32_t (logic [31:0]), FP32_EXP_NAN=8'hFF, NUM_CLASSES_DEF=10, and state enum argmax_state_e {IDLE, ACCUM, DONE}.
- Sub-module fp32_gt: purely combinational strict greater-than with the NaN/zero rules above. It is reusable by other NN blocks.

Test Plan:
- Scores 0.1,0.5,0.2,...(10 beats) with the largest at index 3=2.0, in_last on beat 9, full rate: res_valid at cycle 11, res_class=3, res_err=0.
- All scores negative, -5.0 .. -1.0 with -0.5 at index 7: res_class=7. Ties 1.0 at indices 2 and 6: res_class=2.
- NaN at index 0, 7FC00000 elsewhere, and -inf at index 4 as the only non-NaN: res_class=4. Also +0 at index 0 and -0 at index 1 only: res_class=0.
- in_last on beat 5: DONE after 5 beats, res_err=1. No in_last on beat 9: frame closes, res_err=1.
- res_ready held 0 for 20 cycles in DONE: res_class stable, in_ready=0. Then assert res_ready: handshake completes, and the next frame accepts the following cycle.
- clear asserted at beat 4 of a frame, then a fresh frame with max at index 9: res_class=9, res_err=0. Reset_n pulsed mid-frame: all outputs 0 asynchronously.
